mole_controller: RTL and testbench
==================================

Name: mole_controller

Overview:
- Upstream stage of the score handler in the whack-a-mole game.
- Picks a pseudo-random hole, lights its mole for a fixed window, and watches the player buttons.
- On a correct, timely press it issues a one-cycle `whacked` pulse, which the score handler counts. On timeout it issues a `missed` pulse.
- Sits between the debounced button inputs and the score/display logic.

Parameters:
- NUM_HOLES, 4: number of holes/buttons. Must be a power of two: 4, 8 or 16.
- UP_CYCLES, 8: clock cycles a mole stays visible. Must be ≥ 1.
- GAP_CYCLES, 4: clock cycles with no mole between moles. Must be ≥ 1.
- LFSR_SEED, 8'hA5: LFSR load value. Must be non-zero.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  game running level. Same signal drives the score handler.
- buttons  input  NUM_HOLES  debounced player buttons, active-high level.
- mole  output  NUM_HOLES  one-hot visible mole, or all zero.
- whacked  output  1  one-cycle pulse per successful hit.
- missed  output  1  one-cycle pulse per mole timeout.
- mole_count  output  8  moles shown since game start, saturating at 255.

Behaviour:
- One clock domain: `clk`. Reset is synchronous and active-high, on `rst`. All outputs are registered.
- Reset values: state=IDLE, mole=0, whacked=0, missed=0, mole_count=0, btn_q=0, lfsr=LFSR_SEED, cnt=0, prev_valid=0.
- Button edge detect: btn_q <= buttons every cycle; rise = buttons & ~btn_q. A button already held when a mole appears is not a hit.
- LFSR: 8-bit Fibonacci. next = {q[6:0], q[7]^q[5]^q[4]^q[3]}.
  - Held at LFSR_SEED in IDLE.
  - Advances every cycle in GAP and UP.
- Hole select, at the GAP→UP edge, using the current (pre-update) lfsr:
  - h = lfsr[log2(NUM_HOLES)-1:0].
  - If prev_valid and h == prev_hole, then h = (h+1) mod NUM_HOLES.
  - Store prev_hole = h and set prev_valid = 1.
- IDLE:
  - mole=0, mole_count=0, prev_valid=0.
  - start=1 → GAP with cnt=GAP_CYCLES-1.
- GAP:
  - mole=0.
  - cnt>0: decrement.
  - cnt==0: → UP, mole=onehot(h), cnt=UP_CYCLES-1, mole_count += 1 (saturating at 255).
- UP:
  - rise[h]=1: next edge whacked=1, mole=0, → GAP with cnt=GAP_CYCLES-1.
  - Otherwise cnt==0: next edge missed=1, mole=0, → GAP with cnt=GAP_CYCLES-1.
  - Otherwise decrement cnt.
  - A hit and a timeout on the same cycle count as a hit.
  - A rise on a wrong button is ignored. Multiple rises that include the correct button count as a hit.
- Visibility:
  - Unhit mole: visible exactly UP_CYCLES cycles.
  - Gap: exactly GAP_CYCLES cycles with mole=0.
- Pulses: whacked and missed are each high for exactly one cycle, never together, and default to 0 every cycle.
- start=0 in any state: next edge → IDLE.
  - mole=0, no whacked/missed pulse, lfsr reloads LFSR_SEED.
  - Mid-window abort is neither a hit nor a miss.
- rst has priority over everything; asserting it mid-game returns to the reset values on the next edge.

Test Plan (defaults NUM_HOLES=4, UP=8, GAP=4, SEED=A5):
- First mole: rst, then start=1 at edge E0.
  - lfsr sequence A5→4A→95→2A.
  - At E4 mole=4'b0100 (hole 2) and mole_count=1.
- Timeout: no buttons pressed.
  - mole=4'b0100 for exactly 8 cycles.
  - missed=1 for one cycle as mole clears; whacked stays 0.
  - mole=0 for 4 cycles before the next mole.
- Hit: buttons[2] rises on the 3rd visible cycle.
  - Next edge: whacked=1 for one cycle, mole=0, missed=0.
  - Downstream score goes 0→1.
- Held and wrong buttons:
  - buttons[2] held high before the mole appears → no hit, ends as missed.
  - buttons[0] rising while hole 2 is lit → ignored.
- Abort: start→0 during UP.
  - Next edge mole=0, state IDLE, no pulses.
  - Restarting start=1 reproduces the first-mole sequence, with mole_count restarting at 1.
- Repeat avoidance and saturation:
  - Over 300 consecutive moles, no hole repeats back-to-back.
  - mole_count stops at 255.
  - rst mid-UP clears all outputs on the next edge.

Source files
------------

// File: rtl/mole_controller.sv
// Whack-a-mole hole sequencer: lights a pseudo-random mole for a fixed window,
// watches the debounced buttons and reports a one-cycle hit or miss pulse.
module mole_controller #(
    parameter int unsigned NUM_HOLES  = 4,
    parameter int unsigned UP_CYCLES  = 8,
    parameter int unsigned GAP_CYCLES = 4,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_HOLES-1:0] buttons,
    output logic [NUM_HOLES-1:0] mole,
    output logic                 whacked,
    output logic                 missed,
    output logic [7:0]           mole_count
);

    localparam int unsigned HOLE_W  = $clog2(NUM_HOLES);
    localparam int unsigned CNT_MAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]     CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]     UP_LOAD  = CNT_W'(UP_CYCLES - 1);
    localparam logic [CNT_W-1:0]     GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [NUM_HOLES-1:0] NO_MOLE  = {NUM_HOLES{1'b0}};
    localparam logic [HOLE_W-1:0]    HOLE_ONE = HOLE_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_UP   = 2'd2
    } state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    function automatic logic [NUM_HOLES-1:0] hole_onehot(input logic [HOLE_W-1:0] h);
        logic [NUM_HOLES-1:0] v;
        v    = NO_MOLE;
        v[h] = 1'b1;
        return v;
    endfunction

    state_t               r_state;
    logic [NUM_HOLES-1:0] r_btn_q;
    logic [7:0]           r_lfsr;
    logic [CNT_W-1:0]     r_cnt;
    logic [HOLE_W-1:0]    r_prev_hole;
    logic                 r_prev_valid;
    logic [NUM_HOLES-1:0] r_mole;
    logic                 r_whacked;
    logic                 r_missed;
    logic [7:0]           r_mole_count;

    state_t               w_state_nxt;
    logic [7:0]           w_lfsr_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [HOLE_W-1:0]    w_prev_hole_nxt;
    logic                 w_prev_valid_nxt;
    logic [NUM_HOLES-1:0] w_mole_nxt;
    logic                 w_whacked_nxt;
    logic                 w_missed_nxt;
    logic [7:0]           w_mole_count_nxt;

    logic [NUM_HOLES-1:0] w_rise;
    logic                 w_hit;
    logic [HOLE_W-1:0]    w_hole_raw;
    logic [HOLE_W-1:0]    w_hole;

    // A button held before the mole appears produces no rise, so it cannot score.
    assign w_rise     = buttons & ~r_btn_q;
    assign w_hit      = (r_state == ST_UP) && w_rise[r_prev_hole];
    assign w_hole_raw = r_lfsr[HOLE_W-1:0];
    assign w_hole     = (r_prev_valid && (w_hole_raw == r_prev_hole)) ? (w_hole_raw + HOLE_ONE)
                                                                      : w_hole_raw;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_btn_q      <= NO_MOLE;
            r_lfsr       <= LFSR_SEED;
            r_cnt        <= CNT_ZERO;
            r_prev_hole  <= {HOLE_W{1'b0}};
            r_prev_valid <= 1'b0;
            r_mole       <= NO_MOLE;
            r_whacked    <= 1'b0;
            r_missed     <= 1'b0;
            r_mole_count <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_btn_q      <= buttons;
            r_lfsr       <= w_lfsr_nxt;
            r_cnt        <= w_cnt_nxt;
            r_prev_hole  <= w_prev_hole_nxt;
            r_prev_valid <= w_prev_valid_nxt;
            r_mole       <= w_mole_nxt;
            r_whacked    <= w_whacked_nxt;
            r_missed     <= w_missed_nxt;
            r_mole_count <= w_mole_count_nxt;
        end
    end

    // Next-state selection; dropping start aborts from any state.
    always_comb begin
        w_state_nxt = r_state;
        if (!start) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_GAP;
                ST_GAP: begin
                    if (r_cnt == CNT_ZERO) begin
                        w_state_nxt = ST_UP;
                    end else begin
                        w_state_nxt = ST_GAP;
                    end
                end
                ST_UP: begin
                    if (w_hit || (r_cnt == CNT_ZERO)) begin
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_state_nxt = ST_UP;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Next values of the counter, LFSR, hole memory and registered outputs.
    always_comb begin
        w_lfsr_nxt       = r_lfsr;
        w_cnt_nxt        = r_cnt;
        w_prev_hole_nxt  = r_prev_hole;
        w_prev_valid_nxt = r_prev_valid;
        w_mole_nxt       = r_mole;
        w_whacked_nxt    = 1'b0;
        w_missed_nxt     = 1'b0;
        w_mole_count_nxt = r_mole_count;
        if (!start) begin
            w_lfsr_nxt       = LFSR_SEED;
            w_cnt_nxt        = CNT_ZERO;
            w_prev_valid_nxt = 1'b0;
            w_mole_nxt       = NO_MOLE;
            w_mole_count_nxt = 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_lfsr_nxt       = LFSR_SEED;
                    w_cnt_nxt        = GAP_LOAD;
                    w_prev_valid_nxt = 1'b0;
                    w_mole_nxt       = NO_MOLE;
                    w_mole_count_nxt = 8'd0;
                end
                ST_GAP: begin
                    w_lfsr_nxt = lfsr_next(r_lfsr);
                    if (r_cnt == CNT_ZERO) begin
                        w_mole_nxt       = hole_onehot(w_hole);
                        w_cnt_nxt        = UP_LOAD;
                        w_prev_hole_nxt  = w_hole;
                        w_prev_valid_nxt = 1'b1;
                        if (r_mole_count == 8'hFF) begin
                            w_mole_count_nxt = r_mole_count;
                        end else begin
                            w_mole_count_nxt = r_mole_count + 8'd1;
                        end
                    end else begin
                        w_mole_nxt = NO_MOLE;
                        w_cnt_nxt  = r_cnt - CNT_ONE;
                    end
                end
                ST_UP: begin
                    w_lfsr_nxt = lfsr_next(r_lfsr);
                    if (w_hit) begin
                        w_whacked_nxt = 1'b1;
                        w_mole_nxt    = NO_MOLE;
                        w_cnt_nxt     = GAP_LOAD;
                    end else if (r_cnt == CNT_ZERO) begin
                        w_missed_nxt = 1'b1;
                        w_mole_nxt   = NO_MOLE;
                        w_cnt_nxt    = GAP_LOAD;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    w_lfsr_nxt       = LFSR_SEED;
                    w_cnt_nxt        = CNT_ZERO;
                    w_prev_valid_nxt = 1'b0;
                    w_mole_nxt       = NO_MOLE;
                    w_mole_count_nxt = 8'd0;
                end
            endcase
        end
    end

    assign mole       = r_mole;
    assign whacked    = r_whacked;
    assign missed     = r_missed;
    assign mole_count = r_mole_count;

endmodule

// File: tb/tb_mole_controller.sv
// Directed bench for mole_controller at default parameters (4 holes, 8 up, 4 gap, seed A5).
module tb_mole_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] buttons;
    logic [3:0] mole;
    logic       whacked;
    logic       missed;
    logic [7:0] mole_count;

    int checks   = 0;
    int failures = 0;
    int score    = 0;

    mole_controller dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .buttons    (buttons),
        .mole       (mole),
        .whacked    (whacked),
        .missed     (missed),
        .mole_count (mole_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (whacked) score++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] last_mole;
        logic [3:0] prev_sample;
        int         n;
        int         cyc;

        rst = 1'b1; start = 1'b0; buttons = 4'b0000;
        tick(); tick();
        check("rst_mole", mole, 32'h0);
        check("rst_whacked", whacked, 32'h0);
        check("rst_missed", missed, 32'h0);
        check("rst_count", mole_count, 32'h0);

        // First mole, then an untouched timeout.
        rst = 1'b0; start = 1'b1;
        tick();
        check("gap_e0", mole, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("gap_first", mole, 32'h0);
        end
        tick();
        check("first_mole", mole, 32'h4);
        check("first_count", mole_count, 32'd1);
        for (int i = 5; i <= 11; i++) begin
            tick();
            check("up_mole", mole, 32'h4);
            check("up_no_miss", missed, 32'h0);
        end
        tick();
        check("to_missed", missed, 32'h1);
        check("to_whacked", whacked, 32'h0);
        check("to_mole", mole, 32'h0);
        tick();
        check("to_missed_once", missed, 32'h0);
        check("to_gap1", mole, 32'h0);
        tick(); check("to_gap2", mole, 32'h0);
        tick(); check("to_gap3", mole, 32'h0);
        tick();
        check("second_onehot", {31'd0, $onehot(mole)}, 32'h1);
        check("second_norepeat", {31'd0, mole == 4'b0100}, 32'h0);
        check("second_count", mole_count, 32'd2);
        tick();

        // Abort during UP.
        start = 1'b0;
        tick();
        check("abort_mole", mole, 32'h0);
        check("abort_whacked", whacked, 32'h0);
        check("abort_missed", missed, 32'h0);

        // Restart reproduces hole 2; hit on the 3rd visible cycle.
        start = 1'b1;
        for (int i = 0; i <= 4; i++) tick();
        check("restart_mole", mole, 32'h4);
        check("restart_count", mole_count, 32'd1);
        tick(); tick();
        buttons = 4'b0100;
        tick();
        check("hit_whacked", whacked, 32'h1);
        check("hit_missed", missed, 32'h0);
        check("hit_mole", mole, 32'h0);
        check("hit_score", score, 32'd1);
        tick();
        check("hit_once", whacked, 32'h0);
        check("hit_gap", mole, 32'h0);
        buttons = 4'b0000;

        // Held correct button and a wrong-button rise end as a miss.
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        buttons = 4'b0100;
        for (int i = 1; i <= 4; i++) tick();
        check("held_mole", mole, 32'h4);
        buttons = 4'b0101;
        for (int i = 5; i <= 11; i++) begin
            tick();
            check("held_no_hit", whacked, 32'h0);
            check("held_mole_up", mole, 32'h4);
        end
        tick();
        check("held_missed", missed, 32'h1);
        check("held_whacked", whacked, 32'h0);
        buttons = 4'b0000;

        // Hit on the final visible cycle wins over the timeout.
        start = 1'b0;
        tick();
        start = 1'b1;
        for (int i = 0; i <= 11; i++) tick();
        check("late_mole", mole, 32'h4);
        buttons = 4'b0100;
        tick();
        check("late_whacked", whacked, 32'h1);
        check("late_missed", missed, 32'h0);
        buttons = 4'b0000;

        // Long run: no back-to-back repeats, count saturates at 255.
        start = 1'b0;
        tick();
        start = 1'b1;
        last_mole   = 4'b0000;
        prev_sample = mole;
        n   = 0;
        cyc = 0;
        while (n < 300 && cyc < 5000) begin
            tick();
            cyc++;
            check("pulse_excl", {31'd0, whacked & missed}, 32'h0);
            if (mole != 4'b0000 && prev_sample == 4'b0000) begin
                n++;
                check("run_onehot", {31'd0, $onehot(mole)}, 32'h1);
                if (last_mole != 4'b0000) begin
                    check("run_norepeat", {31'd0, mole == last_mole}, 32'h0);
                end
                check("run_count", mole_count, (n > 255) ? 32'd255 : n);
                last_mole = mole;
            end
            prev_sample = mole;
        end
        check("run_budget", n, 32'd300);
        check("sat_count", mole_count, 32'd255);

        // Reset mid-UP.
        check("pre_rst_up", {31'd0, mole != 4'b0000}, 32'h1);
        rst = 1'b1;
        tick();
        check("midrst_mole", mole, 32'h0);
        check("midrst_count", mole_count, 32'h0);
        check("midrst_whacked", whacked, 32'h0);
        check("midrst_missed", missed, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
